// File: rtl/riscv_v_bw_reduct_seq.sv
// riscv_v_bw_reduct_seq: multi-beat sequencer for vredand/vredor/vredxor.
// Each source beat passes through the shared bitwise unit twice. The first
// pass (FOLD, reduct mode) folds the beat to one element. The second pass
// (COMB) merges that element into an accumulator, which starts from the
// masked scalar operand.
// Optional feature macro: RISCV_V_BW_REDUCT_SEQ_KILL_EN adds a 'kill' input.
// It aborts an in-flight sequence and returns the block to IDLE.
module riscv_v_bw_reduct_seq #(
   parameter int DATA_WIDTH    = 128,
   parameter int MAX_LMUL_LOG2 = 3
) (
   input  logic                       clk,
   input  logic                       rst,
`ifdef RISCV_V_BW_REDUCT_SEQ_KILL_EN
   input  logic                       kill,
`endif
   input  logic                       req_valid,
   output logic                       req_ready,
   input  logic [1:0]                 req_op,
   input  logic [MAX_LMUL_LOG2-1:0]   req_lmul,
   input  logic [1:0]                 req_osize,
   input  logic [63:0]                req_scalar,
   input  logic                       src_valid,
   output logic                       src_ready,
   input  logic [DATA_WIDTH-1:0]      src_data,
   input  logic [DATA_WIDTH/8-1:0]    src_byte_valid,
   output logic                       bw_is_and,
   output logic                       bw_is_or,
   output logic                       bw_is_xor,
   output logic                       bw_is_reduct,
   output logic                       bw_is_reduct_n,
   output logic [3:0]                 bw_osize_vector,
   output logic [DATA_WIDTH-1:0]      bw_srca,
   output logic [DATA_WIDTH-1:0]      bw_srcb,
   output logic [DATA_WIDTH/8-1:0]    bw_srcb_valid,
   input  logic [DATA_WIDTH-1:0]      bw_result,
   output logic                       res_valid,
   input  logic                       res_ready,
   output logic [63:0]                res_data
);

   localparam int NUM_BYTES = DATA_WIDTH / 8;
   localparam logic [MAX_LMUL_LOG2-1:0] LMUL_MAX = MAX_LMUL_LOG2'(MAX_LMUL_LOG2);

   typedef enum logic [1:0] {IDLE, FOLD, COMB, RESP} state_t;

   state_t                   state;
   logic [1:0]               op_q;
   logic [1:0]               osize_q;
   logic [MAX_LMUL_LOG2-1:0] last_q;
   logic [MAX_LMUL_LOG2-1:0] cnt;
   logic [63:0]              acc;
   logic [63:0]              fold;
   logic                     res_valid_q;

   logic [MAX_LMUL_LOG2-1:0] lmul_c;
   logic [MAX_LMUL_LOG2-1:0] last_n;
   logic [63:0]              unit_res;
   logic                     kill_act;
   logic                     sel_and, sel_or, sel_xor;
   logic                     unused_hi;

   // Only the low 64 bits of the unit result carry the folded element.
   assign unused_hi = ^bw_result[DATA_WIDTH-1:64];

   // Keep the low 2^osize bytes of a 64-bit value.
   function automatic logic [63:0] osize_mask(input logic [1:0] s);
      case (s)
         2'd0:    return 64'h0000_0000_0000_00FF;
         2'd1:    return 64'h0000_0000_0000_FFFF;
         2'd2:    return 64'h0000_0000_FFFF_FFFF;
         default: return 64'hFFFF_FFFF_FFFF_FFFF;
      endcase
   endfunction

`ifdef RISCV_V_BW_REDUCT_SEQ_KILL_EN
   assign kill_act = kill && (state != IDLE);
`else
   assign kill_act = 1'b0;
`endif

   // Clamp lmul to the largest supported group and form the index of the last beat.
   always_comb begin
      lmul_c = (req_lmul > LMUL_MAX) ? LMUL_MAX : req_lmul;
      last_n = '0;
      for (int i = 0; i < MAX_LMUL_LOG2; i++)
         last_n[i] = (i < int'(lmul_c));
   end

   assign unit_res = bw_result[63:0] & osize_mask(osize_q);

   // Decode the unit select from the latched op while the unit is in use.
   always_comb begin
      sel_and = 1'b0;
      sel_or  = 1'b0;
      sel_xor = 1'b0;
      if (state == FOLD || state == COMB) begin
         sel_and = (op_q == 2'd0);
         sel_or  = (op_q == 2'd1);
         sel_xor = (op_q == 2'd2);
      end
   end

   // Operand steering to the shared bitwise unit for the fold and merge passes.
   always_comb begin
      bw_is_reduct  = 1'b0;
      bw_srca       = '0;
      bw_srcb       = '0;
      bw_srcb_valid = '0;
      case (state)
         FOLD: begin
            bw_is_reduct = 1'b1;
            if (op_q == 2'd0) begin
               // Inactive bytes become 0xFF so they cannot clear any AND result bits.
               for (int b = 0; b < NUM_BYTES; b++)
                  bw_srcb[8*b +: 8] = src_byte_valid[b] ? src_data[8*b +: 8] : 8'hFF;
               bw_srcb_valid = '1;
            end else begin
               bw_srcb       = src_data;
               bw_srcb_valid = src_byte_valid;
            end
         end
         COMB: begin
            bw_srca = DATA_WIDTH'(acc);
            bw_srcb = DATA_WIDTH'(fold);
            for (int b = 0; b < NUM_BYTES; b++)
               bw_srcb_valid[b] = (b < (1 << osize_q));
         end
         default: ;
      endcase
   end

   assign bw_is_and       = sel_and;
   assign bw_is_or        = sel_or;
   assign bw_is_xor       = sel_xor;
   assign bw_is_reduct_n  = ~bw_is_reduct;
   assign bw_osize_vector = (state != IDLE) ? 4'(4'b0001 << osize_q) : 4'b0000;
   assign src_ready       = (state == FOLD) && !kill_act;
   assign res_valid       = res_valid_q && !kill_act;
   assign res_data        = res_valid_q ? acc : 64'd0;

   // Sequencer: IDLE -> (FOLD -> COMB) x nbeats -> RESP -> IDLE.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         op_q        <= 2'd0;
         osize_q     <= 2'd0;
         last_q      <= '0;
         cnt         <= '0;
         acc         <= 64'd0;
         fold        <= 64'd0;
         req_ready   <= 1'b0;
         res_valid_q <= 1'b0;
      end else if (kill_act) begin
         state       <= IDLE;
         cnt         <= '0;
         acc         <= 64'd0;
         fold        <= 64'd0;
         req_ready   <= 1'b1;
         res_valid_q <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (req_valid && req_ready) begin
                  op_q      <= req_op;
                  osize_q   <= req_osize;
                  last_q    <= last_n;
                  acc       <= req_scalar & osize_mask(req_osize);
                  cnt       <= '0;
                  req_ready <= 1'b0;
                  state     <= FOLD;
               end else begin
                  req_ready <= 1'b1;
               end
            end
            FOLD: begin
               if (src_valid) begin
                  fold  <= unit_res;
                  state <= COMB;
               end
            end
            COMB: begin
               acc <= unit_res;
               if (cnt == last_q) begin
                  res_valid_q <= 1'b1;
                  state       <= RESP;
               end else begin
                  cnt   <= cnt + 1'b1;
                  state <= FOLD;
               end
            end
            RESP: begin
               if (res_ready) begin
                  res_valid_q <= 1'b0;
                  req_ready   <= 1'b1;
                  state       <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_riscv_v_bw_reduct_seq.sv
// Testbench for riscv_v_bw_reduct_seq. It includes a model of the shared
// bitwise unit and a reference model of the reduction. The kill test is built
// only when RISCV_V_BW_REDUCT_SEQ_KILL_EN is defined.
module tb_riscv_v_bw_reduct_seq;
   localparam int DW = 128;
   localparam int NB = DW / 8;
   localparam int ML = 3;

   logic           clk = 1'b0;
   logic           rst;
   logic           req_valid, req_ready;
   logic [1:0]     req_op;
   logic [ML-1:0]  req_lmul;
   logic [1:0]     req_osize;
   logic [63:0]    req_scalar;
   logic           src_valid, src_ready;
   logic [DW-1:0]  src_data;
   logic [NB-1:0]  src_byte_valid;
   logic           bw_is_and, bw_is_or, bw_is_xor, bw_is_reduct, bw_is_reduct_n;
   logic [3:0]     bw_osize_vector;
   logic [DW-1:0]  bw_srca, bw_srcb, bw_result;
   logic [NB-1:0]  bw_srcb_valid;
   logic           res_valid, res_ready;
   logic [63:0]    res_data;
`ifdef RISCV_V_BW_REDUCT_SEQ_KILL_EN
   logic           kill;
`endif

   int errors = 0;
   int checks = 0;
   int phase_err = 0;

   logic [DW-1:0] beats [8];
   logic [NB-1:0] bvs   [8];

   always #5 clk = ~clk;

   riscv_v_bw_reduct_seq #(.DATA_WIDTH(DW), .MAX_LMUL_LOG2(ML)) dut (
      .clk(clk), .rst(rst),
`ifdef RISCV_V_BW_REDUCT_SEQ_KILL_EN
      .kill(kill),
`endif
      .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
      .req_lmul(req_lmul), .req_osize(req_osize), .req_scalar(req_scalar),
      .src_valid(src_valid), .src_ready(src_ready), .src_data(src_data),
      .src_byte_valid(src_byte_valid),
      .bw_is_and(bw_is_and), .bw_is_or(bw_is_or), .bw_is_xor(bw_is_xor),
      .bw_is_reduct(bw_is_reduct), .bw_is_reduct_n(bw_is_reduct_n),
      .bw_osize_vector(bw_osize_vector), .bw_srca(bw_srca), .bw_srcb(bw_srcb),
      .bw_srcb_valid(bw_srcb_valid), .bw_result(bw_result),
      .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data)
   );

   // Behaviour of the external bitwise unit. In reduct mode it folds all
   // elements of srcb into the low element. Otherwise it combines srca and srcb
   // byte by byte, and bytes not valid in srcb give 0.
   function automatic logic [DW-1:0] unit_fn(input logic a_, o_, x_, red,
                                             input logic [3:0] osv,
                                             input logic [DW-1:0] sa, sb,
                                             input logic [NB-1:0] sv);
      int esz;
      logic [63:0] r, e;
      logic [DW-1:0] out;
      out = '0;
      if (!(a_ | o_ | x_)) return out;
      esz = osv[3] ? 8 : osv[2] ? 4 : osv[1] ? 2 : 1;
      if (red) begin
         r = a_ ? '1 : '0;
         for (int i = 0; i < NB / esz; i++) begin
            e = '0;
            for (int b = 0; b < esz; b++)
               if (sv[i*esz+b]) e[8*b +: 8] = sb[8*(i*esz+b) +: 8];
            r = a_ ? (r & e) : o_ ? (r | e) : (r ^ e);
         end
         if (esz < 8) r = r & ((64'd1 << (8 * esz)) - 64'd1);
         out[63:0] = r;
      end else begin
         for (int b = 0; b < NB; b++)
            if (sv[b])
               out[8*b +: 8] = a_ ? (sa[8*b +: 8] & sb[8*b +: 8]) :
                               o_ ? (sa[8*b +: 8] | sb[8*b +: 8]) :
                                    (sa[8*b +: 8] ^ sb[8*b +: 8]);
      end
      return out;
   endfunction

   always_comb bw_result = unit_fn(bw_is_and, bw_is_or, bw_is_xor, bw_is_reduct,
                                   bw_osize_vector, bw_srca, bw_srcb, bw_srcb_valid);

   // Reference model. It applies the op to the scalar and to every active element
   // of every beat. An inactive byte is replaced by the identity of the op.
   function automatic logic [63:0] model(input int op, lmul, osz, input logic [63:0] sc);
      int nb, esz;
      logic [63:0] m, r, e;
      logic [7:0] by;
      nb  = 1 << ((lmul > ML) ? ML : lmul);
      esz = 1 << osz;
      m   = (osz == 3) ? '1 : ((64'd1 << (8 * esz)) - 64'd1);
      if (op == 3) return 64'd0;
      r = sc & m;
      for (int k = 0; k < nb; k++)
         for (int i = 0; i < NB / esz; i++) begin
            e = '0;
            for (int b = 0; b < esz; b++) begin
               by = bvs[k][i*esz+b] ? beats[k][8*(i*esz+b) +: 8] : ((op == 0) ? 8'hFF : 8'h00);
               e  = e | (64'(by) << (8 * b));
            end
            r = (op == 0) ? (r & e) : (op == 1) ? (r | e) : (r ^ e);
         end
      return r & m;
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic chk_idle_outputs(input string nm);
      chk({nm, "_ctl"}, 64'({req_ready, src_ready, bw_is_and, bw_is_or, bw_is_xor,
                             bw_is_reduct, bw_is_reduct_n, bw_osize_vector, res_valid}),
          64'h020);
      chk({nm, "_data"}, 64'((|bw_srca) | (|bw_srcb) | (|bw_srcb_valid) | (|res_data)), 64'd0);
   endtask

   // Runs one full reduction. stall: 0 = none, 1 = random, 2 = every other cycle.
   // Before it sends res_ready, the task holds the result for 'hold' cycles and
   // checks that it stays stable.
   task automatic run_op(input int op, lmul, osz, input logic [63:0] sc, input int stall,
                         input int hold, output logic [63:0] res, output int lat);
      int idx, cyc;
      bit done;
      res = '0;
      lat = -1;
      cyc = 0;
      @(negedge clk);
      while (!req_ready && cyc < 50) begin @(negedge clk); cyc++; end
      req_valid = 1'b1; req_op = op[1:0]; req_lmul = lmul[ML-1:0];
      req_osize = osz[1:0]; req_scalar = sc;
      @(posedge clk);
      idx = 0; cyc = 0; done = 0;
      while (!done && cyc < 400) begin
         @(negedge clk);
         cyc++;
         req_valid = 1'b0;
         if (res_valid) begin
            done = 1; lat = cyc; res = res_data;
         end else begin
            if (bw_is_reduct !== src_ready || bw_is_reduct_n !== ~bw_is_reduct ||
                bw_osize_vector !== 4'(4'b0001 << osz)) phase_err++;
            src_valid = src_ready && (stall == 0 ||
                        (stall == 1 ? ($urandom_range(0, 1) == 1) : (cyc % 2 == 0)));
            src_data = beats[idx % 8];
            src_byte_valid = bvs[idx % 8];
            if (src_valid) idx++;
         end
      end
      src_valid = 1'b0;
      if (done) begin
         for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            chk("hold_valid", 64'(res_valid), 64'd1);
            chk("hold_data", res_data, res);
         end
         res_ready = 1'b1;
         @(posedge clk);
         @(negedge clk);
         res_ready = 1'b0;
      end
   endtask

   typedef struct {
      int op, lmul, osz;
      logic [63:0] sc;
      logic [DW-1:0] d0, d1;
      logic [NB-1:0] v0, v1;
      logic [63:0] exp;
   } vec_t;

   vec_t tbl [7];
   logic [63:0] r, e;
   int lat;

   initial begin
      tbl[0] = '{2, 0, 0, 64'h5A, 128'h100F0E0D0C0B0A090807060504030201, '0, '1, '1, 64'h4A};
      tbl[1] = '{0, 1, 1, 64'hFFFF, 128'hFFFF_FFFF_FFFF_0F0F_FFFF_FFFF_FFFF_FFFF,
                 128'h0000_0000_0000_0000_FFFF_FFFF_FFFF_FFFF, '1, 16'h00FF, 64'h0F0F};
      tbl[2] = '{1, 0, 3, 64'h1, 128'h0000_0001_0000_0000_0000_0000_0000_0080, '0, '1, '1,
                 64'h1_0000_0081};
      tbl[3] = '{3, 1, 2, 64'hFFFF_FFFF, '1, '1, '1, '1, 64'h0};
      tbl[4] = '{0, 0, 0, 64'hF3, 128'h0, 128'h0, 16'h0, 16'h0, 64'hF3};
      tbl[5] = '{2, 7, 2, 64'h1234_5678_9ABC_DEF0, '0, '0, '1, '1, 64'h9ABC_DEF0};
      tbl[6] = '{1, 0, 1, 64'h0001, 128'h0000_FF80, '0, 16'h0001, '0, 64'h0081};

      rst = 1'b1; req_valid = 0; req_op = 0; req_lmul = 0; req_osize = 0; req_scalar = 0;
      src_valid = 0; src_data = 0; src_byte_valid = 0; res_ready = 0;
`ifdef RISCV_V_BW_REDUCT_SEQ_KILL_EN
      kill = 1'b0;
`endif
      #12;
      chk_idle_outputs("reset");
      @(negedge clk) rst = 1'b0;
      @(negedge clk);
      chk("ready_after_reset", 64'(req_ready), 64'd1);

      // Table vectors: the result and the no-stall latency, 2*nbeats+1.
      foreach (tbl[t]) begin
         for (int k = 0; k < 8; k++) begin
            beats[k] = (k % 2) ? tbl[t].d1 : tbl[t].d0;
            bvs[k]   = (k % 2) ? tbl[t].v1 : tbl[t].v0;
         end
         run_op(tbl[t].op, tbl[t].lmul, tbl[t].osz, tbl[t].sc, 0, 0, r, lat);
         chk($sformatf("vec%0d_res", t), r, tbl[t].exp);
         chk($sformatf("vec%0d_lat", t), 64'(lat),
             64'(2 * (1 << ((tbl[t].lmul > ML) ? ML : tbl[t].lmul)) + 1));
      end

      // OR over 8 beats with one bit each; src_valid toggles every other cycle.
      for (int k = 0; k < 8; k++) begin
         beats[k] = 128'd1 << (k * 7 + ((k % 2) ? 64 : 0));
         bvs[k]   = '1;
      end
      run_op(1, 3, 3, 64'd0, 2, 0, r, lat);
      chk("or8_res", r, 64'h0002_0408_1020_4081);
      chk("or8_stalled", 64'(lat > 17), 64'd1);

      // XOR osize 32b lmul 2, with the result held for 5 cycles before it is consumed.
      phase_err = 0;
      for (int k = 0; k < 8; k++) begin
         beats[k] = {$urandom, $urandom, $urandom, $urandom};
         bvs[k] = 16'($urandom);
      end
      e = {$urandom, $urandom};
      run_op(2, 2, 2, e, 0, 5, r, lat);
      chk("phase_res", r, model(2, 2, 2, e));
      chk("phase_reduct", 64'(phase_err), 64'd0);

      // Reset in the middle of COMB.
      @(negedge clk);
      while (!req_ready) @(negedge clk);
      req_valid = 1; req_op = 2'd2; req_lmul = 3'd2; req_osize = 2'd0; req_scalar = 64'hFF;
      @(posedge clk);
      @(negedge clk) req_valid = 0; src_valid = 1; src_data = '1; src_byte_valid = '1;
      @(posedge clk);
      @(negedge clk) src_valid = 0;
      rst = 1'b1;
      #1;
      chk_idle_outputs("midrst");
      @(negedge clk) rst = 1'b0;
      for (int k = 0; k < 8; k++) begin
         beats[k] = {$urandom, $urandom, $urandom, $urandom}; bvs[k] = '1;
      end
      run_op(0, 2, 1, 64'h0000_0000_0000_C3A5, 0, 0, r, lat);
      chk("after_rst_res", r, model(0, 2, 1, 64'h0000_0000_0000_C3A5));

`ifdef RISCV_V_BW_REDUCT_SEQ_KILL_EN
      // Kill during beat 1 of an lmul=1 AND.
      @(negedge clk);
      while (!req_ready) @(negedge clk);
      req_valid = 1; req_op = 2'd0; req_lmul = 3'd1; req_osize = 2'd0; req_scalar = 64'hFF;
      @(posedge clk);
      @(negedge clk) req_valid = 0; src_valid = 1; src_data = '1; src_byte_valid = '1;
      @(posedge clk);
      @(negedge clk) src_valid = 0;
      @(posedge clk);
      @(negedge clk) kill = 1; src_valid = 1;
      #1;
      chk("kill_src_ready", 64'(src_ready), 64'd0);
      @(posedge clk);
      @(negedge clk) kill = 0; src_valid = 0;
      chk("kill_res_valid", 64'(res_valid), 64'd0);
      chk("kill_req_ready", 64'(req_ready), 64'd1);
      run_op(1, 0, 0, 64'h10, 0, 0, r, lat);
      chk("after_kill_res", r, model(1, 0, 0, 64'h10));
`endif

      // Random operations with random stalls, checked against the reference model.
      for (int n = 0; n < 24; n++) begin
         int op, lm, os;
         op = $urandom_range(0, 3); lm = $urandom_range(0, 7); os = $urandom_range(0, 3);
         e = {$urandom, $urandom};
         for (int k = 0; k < 8; k++) begin
            beats[k] = {$urandom, $urandom, $urandom, $urandom};
            bvs[k] = ($urandom_range(0, 2) == 0) ? '1 : 16'($urandom);
         end
         run_op(op, lm, os, e, 1, 0, r, lat);
         chk($sformatf("rand%0d op%0d lmul%0d os%0d", n, op, lm, os), r, model(op, lm, os, e));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end
endmodule
